control_unit: RTL
=================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter AUTO_RUN, default 0; when 1, leaves IDLE on the first clock after reset without needing run.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on posedge clk.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port run, input, 1, start/continue request.
REQ-005 SHALL have port ir_opcode, input, 4, IR[15:12] of the current instruction.
REQ-006 SHALL have port acc_zero, input, 1, high when ACC == 16'h0000.
REQ-007 SHALL have ports pc_write, mar_write, mbr_write, ir_write, acc_write, mem_write, output, 1 each, register and memory write enables.
REQ-008 SHALL have ports pc_sel (0=PC+1, 1=IR[11:0]), mar_sel (0=PC, 1=IR[11:0]), mbr_sel (0=memory data_out, 1=ACC), acc_sel (0=MBR, 1=ALU result), output, 1 each.
REQ-009 SHALL have port alu_op, output, 4, ALU operation code.
REQ-010 SHALL have ports halted (in HALT) and busy (not IDLE and not HALT), output, 1 each.

Function
REQ-011 SHALL implement a Moore FSM with states IDLE, F1, F2, F3, D, E1, E2, E3, E4, HALT; outputs are decoded from state and, in E-states only, ir_opcode and acc_zero.
REQ-012 SHALL drive all enables 0 in any state or opcode not listed below.
REQ-013 IDLE -> F1 when run=1 or AUTO_RUN=1; otherwise IDLE holds.
REQ-014 F1: mar_sel=0, mar_write=1. F2: pc_sel=0, pc_write=1 (memory read cycle). F3: mbr_sel=0, mbr_write=1. D: ir_write=1. Each goes to the next state unconditionally.
REQ-015 Opcodes: 0 HALT, 1 LOAD, 2 STORE, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR, 8 JUMP, 9 SKIPZ, A SHL; B-F execute as NOP.
REQ-016 ALU mapping: ADD 4'b0000, SUB 4'b0001, AND 4'b1000, OR 4'b1001, XOR 4'b1010, SHL 4'b0100; alu_op = 4'b0000 otherwise.
REQ-017 E1: LOAD/STORE/ADD-XOR assert mar_sel=1, mar_write=1 -> E2. JUMP: pc_sel=1, pc_write=1. SKIPZ: pc_sel=0, pc_write=acc_zero. SHL: acc_sel=1, acc_write=1. JUMP, SKIPZ, SHL and NOP end the instruction. HALT -> HALT.
REQ-018 E2: STORE asserts mbr_sel=1, mbr_write=1; LOAD/ALU ops are the memory read wait; all -> E3.
REQ-019 E3: STORE asserts mem_write=1 and ends the instruction; LOAD/ALU ops assert mbr_sel=0, mbr_write=1 -> E4.
REQ-020 E4: LOAD acc_sel=0; ALU ops acc_sel=1 with REQ-016 alu_op; acc_write=1; ends the instruction.
REQ-021 Instruction end -> F1 if run=1 or AUTO_RUN=1, else IDLE; run is sampled only at IDLE and instruction end, so deasserting it mid-instruction never truncates the instruction.
REQ-022 Latency SHALL be 8 cycles for LOAD/ALU-memory ops, 7 for STORE, and 5 for JUMP/SKIPZ/SHL/NOP, measured from F1 to the next F1.
REQ-023 HALT is absorbing until reset; halted=1, busy=0, all enables 0.
REQ-024 PC wrap-around is owned by the datapath; control_unit asserts pc_write identically at PC=16'hFFFF.

Reset
REQ-025 Reset SHALL force IDLE asynchronously, including mid-instruction; all outputs 0 while reset is high, and any write in flight is dropped.
REQ-026 Reset SHALL clear instr_count to 0 when present.

Configuration
REQ-027 With CU_INSTR_COUNT_EN defined, SHALL add output instr_count[15:0], incremented at every instruction end including HALT entry, wrapping 16'hFFFF->0; without it the port and counter SHALL not exist.

Structure
REQ-028 Opcode constants, ALU op codes, select encodings and the state enum SHALL live in shared package computer_pkg.
REQ-029 Opcode classification (mem-read, store, alu, branch, halt) SHALL be one combinational sub-module cu_decoder; the FSM stays in control_unit.

Verification
REQ-030 Reset mid-E3 of STORE -> mem_write never asserted; next cycle state IDLE, all outputs 0.
REQ-031 run=1, ir_opcode=1 (LOAD) -> enable sequence mar,pc,mbr,ir,mar,-,mbr,acc(acc_sel=0) over 8 cycles, then F1.
REQ-032 ir_opcode=4 (SUB) -> alu_op=4'b0001, acc_sel=1, acc_write=1 only in cycle 8.
REQ-033 ir_opcode=9: acc_zero=1 -> pc_write=1 in E1; acc_zero=0 -> pc_write=0; both 5 cycles.
REQ-034 ir_opcode=0 -> halted=1 from cycle 6; run toggling -> no enables until reset.
REQ-035 run dropped during E2 of ADD -> instruction completes (acc_write in E4), then IDLE; with CU_INSTR_COUNT_EN, instr_count increments by 1.

Source files
------------

// File: rtl/computer_pkg.sv
// Shared constants for the accumulator machine: opcodes, ALU codes,
// datapath select encodings and the control FSM state type.
package computer_pkg;

    localparam logic [3:0] OP_HALT  = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_XOR   = 4'h7;
    localparam logic [3:0] OP_JUMP  = 4'h8;
    localparam logic [3:0] OP_SKIPZ = 4'h9;
    localparam logic [3:0] OP_SHL   = 4'hA;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b1000;
    localparam logic [3:0] ALU_OR  = 4'b1001;
    localparam logic [3:0] ALU_XOR = 4'b1010;
    localparam logic [3:0] ALU_SHL = 4'b0100;

    localparam logic PC_SEL_INC  = 1'b0;
    localparam logic PC_SEL_IR   = 1'b1;
    localparam logic MAR_SEL_PC  = 1'b0;
    localparam logic MAR_SEL_IR  = 1'b1;
    localparam logic MBR_SEL_MEM = 1'b0;
    localparam logic MBR_SEL_ACC = 1'b1;
    localparam logic ACC_SEL_MBR = 1'b0;
    localparam logic ACC_SEL_ALU = 1'b1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_F1,
        S_F2,
        S_F3,
        S_D,
        S_E1,
        S_E2,
        S_E3,
        S_E4,
        S_HALT
    } state_t;

endpackage

// File: rtl/cu_decoder.sv
// Combinational opcode classifier; mem_rd covers LOAD and the
// memory-operand ALU ops, alu only the ALU subset.
module cu_decoder
    import computer_pkg::*;
(
    input  logic [3:0] opcode_i,
    output logic       mem_rd_o,
    output logic       store_o,
    output logic       alu_o,
    output logic       jump_o,
    output logic       skipz_o,
    output logic       shl_o,
    output logic       halt_o,
    output logic       nop_o,
    output logic [3:0] alu_op_o
);

    always_comb begin
        mem_rd_o = 1'b0;
        store_o  = 1'b0;
        alu_o    = 1'b0;
        jump_o   = 1'b0;
        skipz_o  = 1'b0;
        shl_o    = 1'b0;
        halt_o   = 1'b0;
        nop_o    = 1'b0;
        alu_op_o = ALU_ADD;
        unique case (opcode_i)
            OP_HALT:  halt_o = 1'b1;
            OP_LOAD:  mem_rd_o = 1'b1;
            OP_STORE: store_o = 1'b1;
            OP_ADD: begin
                mem_rd_o = 1'b1;
                alu_o    = 1'b1;
                alu_op_o = ALU_ADD;
            end
            OP_SUB: begin
                mem_rd_o = 1'b1;
                alu_o    = 1'b1;
                alu_op_o = ALU_SUB;
            end
            OP_AND: begin
                mem_rd_o = 1'b1;
                alu_o    = 1'b1;
                alu_op_o = ALU_AND;
            end
            OP_OR: begin
                mem_rd_o = 1'b1;
                alu_o    = 1'b1;
                alu_op_o = ALU_OR;
            end
            OP_XOR: begin
                mem_rd_o = 1'b1;
                alu_o    = 1'b1;
                alu_op_o = ALU_XOR;
            end
            OP_JUMP:  jump_o = 1'b1;
            OP_SKIPZ: skipz_o = 1'b1;
            OP_SHL: begin
                shl_o    = 1'b1;
                alu_op_o = ALU_SHL;
            end
            default:  nop_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle Moore control FSM for the accumulator machine.
// Define CU_INSTR_COUNT_EN to add the instr_count retired-instruction output.
module control_unit
    import computer_pkg::*;
#(
    parameter int AUTO_RUN = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [3:0] ir_opcode,
    input  logic       acc_zero,
    output logic       pc_write,
    output logic       mar_write,
    output logic       mbr_write,
    output logic       ir_write,
    output logic       acc_write,
    output logic       mem_write,
    output logic       pc_sel,
    output logic       mar_sel,
    output logic       mbr_sel,
    output logic       acc_sel,
    output logic [3:0] alu_op,
    output logic       halted,
    output logic       busy
`ifdef CU_INSTR_COUNT_EN
    ,
    output logic [15:0] instr_count
`endif
);

    localparam logic AUTO = (AUTO_RUN != 0);

    state_t     state_q, state_d;
    logic       mem_rd, store, alu, jump, skipz, shl, halt, nop;
    logic [3:0] dec_alu;
    logic       go, instr_end, halt_enter;

    cu_decoder u_dec (
        .opcode_i (ir_opcode),
        .mem_rd_o (mem_rd),
        .store_o  (store),
        .alu_o    (alu),
        .jump_o   (jump),
        .skipz_o  (skipz),
        .shl_o    (shl),
        .halt_o   (halt),
        .nop_o    (nop),
        .alu_op_o (dec_alu)
    );

    assign go = run | AUTO;
    assign halt_enter = (state_q == S_E1) & halt;
    assign instr_end = ((state_q == S_E1) & (jump | skipz | shl | nop))
                     | ((state_q == S_E3) & store)
                     | (state_q == S_E4);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: state_d = go ? S_F1 : S_IDLE;
            S_F1:   state_d = S_F2;
            S_F2:   state_d = S_F3;
            S_F3:   state_d = S_D;
            S_D:    state_d = S_E1;
            S_E1: begin
                if (halt)
                    state_d = S_HALT;
                else if (mem_rd | store)
                    state_d = S_E2;
                else
                    state_d = go ? S_F1 : S_IDLE;
            end
            S_E2:   state_d = S_E3;
            S_E3: begin
                if (store)
                    state_d = go ? S_F1 : S_IDLE;
                else
                    state_d = S_E4;
            end
            S_E4:   state_d = go ? S_F1 : S_IDLE;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        pc_write  = 1'b0;
        mar_write = 1'b0;
        mbr_write = 1'b0;
        ir_write  = 1'b0;
        acc_write = 1'b0;
        mem_write = 1'b0;
        pc_sel    = PC_SEL_INC;
        mar_sel   = MAR_SEL_PC;
        mbr_sel   = MBR_SEL_MEM;
        acc_sel   = ACC_SEL_MBR;
        alu_op    = ALU_ADD;
        unique case (state_q)
            S_F1: mar_write = 1'b1;
            S_F2: pc_write = 1'b1;
            S_F3: mbr_write = 1'b1;
            S_D:  ir_write = 1'b1;
            S_E1: begin
                if (mem_rd | store) begin
                    mar_sel   = MAR_SEL_IR;
                    mar_write = 1'b1;
                end
                if (jump) begin
                    pc_sel   = PC_SEL_IR;
                    pc_write = 1'b1;
                end
                if (skipz)
                    pc_write = acc_zero;
                if (shl) begin
                    acc_sel   = ACC_SEL_ALU;
                    acc_write = 1'b1;
                    alu_op    = dec_alu;
                end
            end
            S_E2: begin
                if (store) begin
                    mbr_sel   = MBR_SEL_ACC;
                    mbr_write = 1'b1;
                end
            end
            S_E3: begin
                if (store)
                    mem_write = 1'b1;
                else if (mem_rd)
                    mbr_write = 1'b1;
            end
            S_E4: begin
                acc_write = 1'b1;
                if (alu) begin
                    acc_sel = ACC_SEL_ALU;
                    alu_op  = dec_alu;
                end
            end
            default: ;
        endcase
    end

    assign halted = (state_q == S_HALT);
    assign busy   = (state_q != S_IDLE) & (state_q != S_HALT);

`ifdef CU_INSTR_COUNT_EN
    logic [15:0] cnt_q, cnt_d;

    assign cnt_d = cnt_q + 16'(instr_end | halt_enter);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign instr_count = cnt_q;
`endif

endmodule
